// File: rtl/l2_pkg.sv
// Types shared by the L2 cacheline responder and the L2 URAM wrapper.
// Holds the responder FSM encoding and the cacheline payload type.
package l2_pkg;

    localparam int CL_SIZE    = 8;
    localparam int DATA_WIDTH = 32;

    typedef logic [CL_SIZE*DATA_WIDTH-1:0] cl_data_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        RESP
    } state_t;

endpackage

// File: rtl/base_rr_arb.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping at n.
// Produces a one-hot grant plus the binary index of the winner.
module base_rr_arb #(
    parameter int n  = 64,
    parameter int iw = $clog2(n)
) (
    input  logic [n-1:0]  req,
    input  logic [iw-1:0] ptr,
    output logic [n-1:0]  gnt,
    output logic [iw-1:0] gnt_idx,
    output logic          gnt_v
);

    logic [iw-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_v   = 1'b0;
        idx     = '0;
        for (int i = 0; i < n; i++) begin
            idx = iw'((int'(ptr) + i) % n);
            if (!gnt_v && req[idx]) begin
                gnt_v      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/l2_cl_responder.sv
// L2-side responder: arbitrates per-stream cacheline requests, copies the next
// L2 URAM line into the stream's next L1 BRAM slot, then acknowledges the stream.
module l2_cl_responder
    import l2_pkg::*;
#(
    parameter int nstrms        = 64,
    parameter int ncl           = 16,
    parameter int l2_ncl        = 256,
    parameter int cl_size       = CL_SIZE,
    parameter int data_width    = DATA_WIDTH,
    parameter int sid_width     = $clog2(nstrms),
    parameter int clid_width    = $clog2(ncl),
    parameter int l2_clid_width = $clog2(l2_ncl)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [nstrms-1:0]             i_rst_v,
    output logic [nstrms-1:0]             i_rst_r,
    input  logic [nstrms-1:0]             i_req_v,
    output logic [nstrms-1:0]             i_req_r,
    output logic [nstrms-1:0]             o_rsp_v,
    input  logic [nstrms-1:0]             o_rsp_r,
    output logic                          o_urd_v,
    input  logic                          o_urd_r,
    output logic [sid_width-1:0]          o_urd_sid,
    output logic [l2_clid_width-1:0]      o_urd_clid,
    input  logic                          i_urd_v,
    output logic                          i_urd_r,
    input  logic [cl_size*data_width-1:0] i_urd_d,
    output logic                          o_wr_v,
    input  logic                          o_wr_r,
    output logic [sid_width-1:0]          o_wr_sid,
    output logic [clid_width-1:0]         o_wr_clid,
    output logic [cl_size*data_width-1:0] o_wr_d
);

    localparam int dw = cl_size * data_width;

    state_t                   state_reg, state_next;
    logic [sid_width-1:0]     sid_reg, sid_next;
    logic [sid_width-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [dw-1:0]            data_reg;
    logic [clid_width-1:0]    l1_ptr_reg [nstrms];
    logic [l2_clid_width-1:0] l2_ptr_reg [nstrms];

    logic [nstrms-1:0]        req_masked;
    logic [nstrms-1:0]        gnt_vec;
    logic [nstrms-1:0]        sid_sel;
    logic [nstrms-1:0]        rst_hs;
    logic [sid_width-1:0]     gnt_idx;
    logic                     gnt_v;
    logic                     wr_hs;

    // A stream with a functional reset pending loses arbitration that cycle.
    assign req_masked = i_req_v & ~i_rst_v;
    assign rst_hs     = i_rst_v & i_rst_r;
    assign wr_hs      = o_wr_v & o_wr_r;

    generate
        for (genvar gi = 0; gi < nstrms; gi++) begin : g_sel
            assign sid_sel[gi] = (sid_reg == sid_width'(gi));
        end
    endgenerate

    base_rr_arb #(
        .n  (nstrms),
        .iw (sid_width)
    ) u_arb (
        .req     (req_masked),
        .ptr     (rr_ptr_reg),
        .gnt     (gnt_vec),
        .gnt_idx (gnt_idx),
        .gnt_v   (gnt_v)
    );

    always_comb begin
        state_next  = state_reg;
        sid_next    = sid_reg;
        rr_ptr_next = rr_ptr_reg;
        i_req_r     = '0;
        i_rst_r     = ~sid_sel;
        o_rsp_v     = '0;
        o_urd_v     = 1'b0;
        o_urd_sid   = '0;
        o_urd_clid  = '0;
        i_urd_r     = 1'b0;
        o_wr_v      = 1'b0;
        o_wr_sid    = '0;
        o_wr_clid   = '0;
        o_wr_d      = '0;
        case (state_reg)
            IDLE: begin
                i_rst_r = '1;
                if (gnt_v) begin
                    i_req_r     = gnt_vec;
                    sid_next    = gnt_idx;
                    rr_ptr_next = (gnt_idx == sid_width'(nstrms - 1)) ? '0 : gnt_idx + 1'b1;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                o_urd_v    = 1'b1;
                o_urd_sid  = sid_reg;
                o_urd_clid = l2_ptr_reg[sid_reg];
                if (o_urd_r) state_next = WAIT;
            end
            WAIT: begin
                i_urd_r = 1'b1;
                if (i_urd_v) state_next = WRITE;
            end
            WRITE: begin
                o_wr_v    = 1'b1;
                o_wr_sid  = sid_reg;
                o_wr_clid = l1_ptr_reg[sid_reg];
                o_wr_d    = data_reg;
                if (o_wr_r) state_next = RESP;
            end
            RESP: begin
                o_rsp_v = sid_sel;
                if (|(o_rsp_r & sid_sel)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Outputs are forced low for as long as reset is held, not just after the edge.
        if (!reset) begin
            i_req_r    = '0;
            i_rst_r    = '0;
            o_rsp_v    = '0;
            o_urd_v    = 1'b0;
            o_urd_sid  = '0;
            o_urd_clid = '0;
            i_urd_r    = 1'b0;
            o_wr_v     = 1'b0;
            o_wr_sid   = '0;
            o_wr_clid  = '0;
            o_wr_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            sid_reg    <= '0;
            rr_ptr_reg <= '0;
            data_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            sid_reg    <= sid_next;
            rr_ptr_reg <= rr_ptr_next;
            if (state_reg == WAIT && i_urd_v) data_reg <= i_urd_d;
        end
    end

    // Functional reset of a stream never collides with its own write: i_rst_r is low while busy on it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < nstrms; i++) begin
                l1_ptr_reg[i] <= '0;
                l2_ptr_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < nstrms; i++) begin
                if (rst_hs[i]) begin
                    l1_ptr_reg[i] <= '0;
                    l2_ptr_reg[i] <= '0;
                end else if (wr_hs && sid_sel[i]) begin
                    l1_ptr_reg[i] <= (l1_ptr_reg[i] == clid_width'(ncl - 1)) ? '0 : l1_ptr_reg[i] + 1'b1;
                    l2_ptr_reg[i] <= (l2_ptr_reg[i] == l2_clid_width'(l2_ncl - 1)) ? '0 : l2_ptr_reg[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_l2_cl_responder.sv
// Self-checking bench for l2_cl_responder: randomized traffic against a
// stream-pointer / round-robin reference model, one line per transaction.
module tb_l2_cl_responder;

    localparam int NS  = 64;
    localparam int NCL = 16;
    localparam int L2N = 256;
    localparam int DW  = 256;

    logic          clk;
    logic          reset;
    logic [NS-1:0] i_rst_v, i_rst_r, i_req_v, i_req_r, o_rsp_v, o_rsp_r;
    logic          o_urd_v, o_urd_r, i_urd_v, i_urd_r, o_wr_v, o_wr_r;
    logic [5:0]    o_urd_sid, o_wr_sid;
    logic [7:0]    o_urd_clid;
    logic [3:0]    o_wr_clid;
    logic [DW-1:0] i_urd_d, o_wr_d;

    int vectors = 0;
    int miscompares = 0;
    int wr_count = 0;

    // reference model: per-stream next-line counters and the arbitration start point
    int l1p [NS];
    int l2p [NS];
    int rr;

    l2_cl_responder dut (
        .clk(clk), .reset(reset),
        .i_rst_v(i_rst_v), .i_rst_r(i_rst_r),
        .i_req_v(i_req_v), .i_req_r(i_req_r),
        .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r),
        .o_urd_v(o_urd_v), .o_urd_r(o_urd_r), .o_urd_sid(o_urd_sid), .o_urd_clid(o_urd_clid),
        .i_urd_v(i_urd_v), .i_urd_r(i_urd_r), .i_urd_d(i_urd_d),
        .o_wr_v(o_wr_v), .o_wr_r(o_wr_r), .o_wr_sid(o_wr_sid), .o_wr_clid(o_wr_clid), .o_wr_d(o_wr_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (reset && o_wr_v && o_wr_r) wr_count++;

    function automatic void model_clear_all();
        for (int i = 0; i < NS; i++) begin
            l1p[i] = 0;
            l2p[i] = 0;
        end
        rr = 0;
    endfunction

    function automatic int model_pick();
        for (int i = 0; i < NS; i++) begin
            int s;
            s = (rr + i) % NS;
            if (i_req_v[s] && !i_rst_v[s]) return s;
        end
        return -1;
    endfunction

    // Services the request the model predicts; caller holds i_req_v. Called at posedge+1.
    task automatic serve(input int urd_bp, input int wr_bp, input int rsp_bp, input bit rst_busy);
        int exp_sid, waited;
        logic [NS-1:0] oh;
        logic [DW-1:0] d;
        exp_sid = model_pick();
        if (exp_sid < 0) begin
            vectors++; miscompares++;
            $display("FAIL serve_setup: no pending request, required one");
            return;
        end
        oh = '0;
        oh[exp_sid] = 1'b1;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        #1;
        waited = 0;
        while (i_req_r === '0 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        vectors++;
        if (i_req_r !== oh) begin
            miscompares++;
            $display("FAIL grant: i_req_r=%h required=%h", i_req_r, oh);
            if (i_req_r === '0) begin
                i_req_v[exp_sid] = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        i_req_v[exp_sid] = 1'b0;
        rr = (exp_sid + 1) % NS;
        if (rst_busy) i_rst_v[exp_sid] = 1'b1;
        for (int c = 0; c <= urd_bp; c++) begin
            o_urd_r = (c == urd_bp);
            #1;
            vectors++;
            if (o_urd_v !== 1'b1 || o_urd_sid !== 6'(exp_sid) || o_urd_clid !== 8'(l2p[exp_sid])) begin
                miscompares++;
                $display("FAIL urd_addr: v=%0b sid=%0d clid=%0d required v=1 sid=%0d clid=%0d",
                         o_urd_v, o_urd_sid, o_urd_clid, exp_sid, l2p[exp_sid]);
            end
            if (rst_busy) begin
                vectors++;
                if (i_rst_r !== ~oh) begin
                    miscompares++;
                    $display("FAIL rst_r_busy_issue: i_rst_r=%h required=%h", i_rst_r, ~oh);
                end
            end
            @(posedge clk); #1;
        end
        o_urd_r = 1'b0;
        vectors++;
        if (i_urd_r !== 1'b1 || o_urd_v !== 1'b0) begin
            miscompares++;
            $display("FAIL urd_wait: i_urd_r=%0b o_urd_v=%0b required 1/0", i_urd_r, o_urd_v);
        end
        i_urd_v = 1'b1;
        i_urd_d = d;
        @(posedge clk); #1;
        i_urd_v = 1'b0;
        i_urd_d = ~d;
        for (int c = 0; c <= wr_bp; c++) begin
            o_wr_r = (c == wr_bp);
            #1;
            vectors++;
            if (o_wr_v !== 1'b1 || o_wr_sid !== 6'(exp_sid) || o_wr_clid !== 4'(l1p[exp_sid]) || o_wr_d !== d) begin
                miscompares++;
                $display("FAIL l1_write: v=%0b sid=%0d clid=%0d d=%h required sid=%0d clid=%0d d=%h",
                         o_wr_v, o_wr_sid, o_wr_clid, o_wr_d, exp_sid, l1p[exp_sid], d);
            end
            if (rst_busy) begin
                vectors++;
                if (i_rst_r !== ~oh) begin
                    miscompares++;
                    $display("FAIL rst_r_busy_write: i_rst_r=%h required=%h", i_rst_r, ~oh);
                end
            end
            @(posedge clk); #1;
        end
        o_wr_r = 1'b0;
        for (int c = 0; c <= rsp_bp; c++) begin
            o_rsp_r = (c == rsp_bp) ? oh : ({$urandom, $urandom} & ~oh);
            #1;
            vectors++;
            if (o_rsp_v !== oh || o_wr_v !== 1'b0) begin
                miscompares++;
                $display("FAIL response: o_rsp_v=%h o_wr_v=%0b required=%h/0", o_rsp_v, o_wr_v, oh);
            end
            @(posedge clk); #1;
        end
        o_rsp_r = '0;
        vectors++;
        if (o_rsp_v !== '0) begin
            miscompares++;
            $display("FAIL rsp_drop: o_rsp_v=%h required=0", o_rsp_v);
        end
        $display("txn sid=%0d urd_clid=%0d wr_clid=%0d bp=%0d/%0d/%0d",
                 exp_sid, l2p[exp_sid], l1p[exp_sid], urd_bp, wr_bp, rsp_bp);
        l1p[exp_sid] = (l1p[exp_sid] + 1) % NCL;
        l2p[exp_sid] = (l2p[exp_sid] + 1) % L2N;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        i_req_v = {$urandom, $urandom};
        i_rst_v = {$urandom, $urandom};
        o_rsp_r = '1;
        o_urd_r = 1'b1;
        o_wr_r  = 1'b1;
        i_urd_v = 1'b1;
        i_urd_d = {8{$urandom}};
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (i_req_r !== '0 || i_rst_r !== '0 || i_urd_r !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_readies: i_req_r=%h i_rst_r=%h i_urd_r=%0b required all 0", i_req_r, i_rst_r, i_urd_r);
        end
        vectors++;
        if (o_rsp_v !== '0 || o_urd_v !== 1'b0 || o_wr_v !== 1'b0 || o_wr_d !== '0 || o_urd_clid !== '0) begin
            miscompares++;
            $display("FAIL reset_valids: o_rsp_v=%h o_urd_v=%0b o_wr_v=%0b required all 0", o_rsp_v, o_urd_v, o_wr_v);
        end
        i_req_v = '0; i_rst_v = '0; o_rsp_r = '0; o_urd_r = 1'b0; o_wr_r = 1'b0; i_urd_v = 1'b0;
        reset = 1'b1;
        model_clear_all();
        #1;
        vectors++;
        if (i_rst_r !== '1 || i_req_r !== '0 || o_urd_v !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: i_rst_r=%h i_req_r=%h required all-ones/0", i_rst_r, i_req_r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        repeat (2) begin
            i_req_v[5] = 1'b1;
            serve(0, 0, 0, 0);
        end
    endtask

    task automatic test_rr_wrap();
        i_req_v[0] = 1'b1; i_req_v[3] = 1'b1; i_req_v[63] = 1'b1;
        repeat (3) serve(0, 0, 0, 0);
        i_req_v[0] = 1'b1; i_req_v[5] = 1'b1;
        repeat (2) serve(0, 0, 0, 0);
    endtask

    task automatic test_ptr_wrap();
        repeat (17) begin
            i_req_v[2] = 1'b1;
            serve(0, 0, 0, 0);
        end
    endtask

    task automatic test_backpressure();
        int w0;
        w0 = wr_count;
        i_req_v[9] = 1'b1;
        serve(5, 5, 5, 0);
        vectors++;
        if (wr_count - w0 !== 1) begin
            miscompares++;
            $display("FAIL write_count: writes=%0d required=1", wr_count - w0);
        end
    endtask

    task automatic test_stream_reset();
        repeat (3) begin
            i_req_v[7] = 1'b1;
            serve(0, 0, 0, 0);
        end
        i_req_v[7] = 1'b1;
        serve(1, 1, 1, 1);
        vectors++;
        if (i_rst_r[7] !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_r_idle: i_rst_r[7]=%0b required=1", i_rst_r[7]);
        end
        @(posedge clk); #1;
        i_rst_v[7] = 1'b0;
        l1p[7] = 0; l2p[7] = 0;
        i_req_v[7] = 1'b1;
        serve(0, 0, 0, 0);
        // several resets at once, one colliding with a request on the same stream
        i_rst_v[5] = 1'b1; i_rst_v[2] = 1'b1; i_rst_v[9] = 1'b1;
        i_req_v[5] = 1'b1;
        #1;
        vectors++;
        if (i_req_r !== '0 || i_rst_r !== '1) begin
            miscompares++;
            $display("FAIL rst_vs_req: i_req_r=%h i_rst_r=%h required 0/all-ones", i_req_r, i_rst_r);
        end
        @(posedge clk); #1;
        i_rst_v = '0;
        l1p[5] = 0; l2p[5] = 0; l1p[2] = 0; l2p[2] = 0; l1p[9] = 0; l2p[9] = 0;
        serve(0, 0, 0, 0);
        i_req_v[2] = 1'b1; i_req_v[9] = 1'b1;
        repeat (2) serve(0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            int n, guard;
            if ($urandom_range(0, 2) == 0) begin
                int s;
                s = $urandom_range(0, NS - 1);
                i_rst_v[s] = 1'b1;
                #1;
                vectors++;
                if (i_rst_r !== '1) begin
                    miscompares++;
                    $display("FAIL rand_rst_r: i_rst_r=%h required all-ones", i_rst_r);
                end
                @(posedge clk); #1;
                i_rst_v[s] = 1'b0;
                l1p[s] = 0; l2p[s] = 0;
            end
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) i_req_v[$urandom_range(0, NS - 1)] = 1'b1;
            guard = 0;
            while (i_req_v !== '0 && guard < 8) begin
                serve($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 0);
                guard++;
            end
            i_req_v = '0;
        end
    endtask

    task automatic test_async_reset();
        i_req_v[12] = 1'b1;
        #1;
        @(posedge clk); #1;
        i_req_v = '0;
        o_urd_r = 1'b1;
        @(posedge clk); #1;
        o_urd_r = 1'b0;
        vectors++;
        if (i_urd_r !== 1'b1) begin
            miscompares++;
            $display("FAIL reach_wait: i_urd_r=%0b required=1", i_urd_r);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (i_urd_r !== 1'b0 || i_rst_r !== '0 || o_rsp_v !== '0 || o_urd_v !== 1'b0 || o_wr_v !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: i_urd_r=%0b i_rst_r=%h o_rsp_v=%h required all 0", i_urd_r, i_rst_r, o_rsp_v);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        model_clear_all();
        i_req_v[63] = 1'b1; i_req_v[5] = 1'b1;
        repeat (2) serve(0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        i_rst_v = '0; i_req_v = '0; o_rsp_r = '0;
        o_urd_r = 1'b0; o_wr_r = 1'b0; i_urd_v = 1'b0; i_urd_d = '0;
        model_clear_all();
        test_reset();
        test_single();
        test_rr_wrap();
        test_ptr_wrap();
        test_backpressure();
        test_stream_reset();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
